// File: rtl/hc193_clk.sv
// hc193_clk: clk-synchronous 74HC193 presettable 4-bit up/down counter with cascade carry/borrow
module hc193_clk #(
  parameter int SYNC_STAGES = 0,
  parameter bit TC_REG      = 0
) (
  input  logic clk,
  input  logic p14,
  input  logic p5,
  input  logic p4,
  input  logic p11,
  input  logic p15,
  input  logic p1,
  input  logic p10,
  input  logic p9,
  output logic p3,
  output logic p2,
  output logic p6,
  output logic p7,
  output logic p12,
  output logic p13
);
  logic [2:0] raw, s;
  logic ld_n, up_s, dn_s, prev_up, prev_dn, up_edge, dn_edge, tcu_c, tcd_c;
  logic [3:0] q;
  assign raw = {p11, p5, p4};
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s = raw;
    end else begin : g_sync
      logic [2:0] sh [SYNC_STAGES];
      // Idle-high reset keeps pulse pins from looking like fresh edges after clear
      always_ff @(posedge clk or posedge p14)
        if (p14) for (int i = 0; i < SYNC_STAGES; i++) sh[i] <= '1;
        else begin
          sh[0] <= raw;
          for (int i = 1; i < SYNC_STAGES; i++) sh[i] <= sh[i-1];
        end
      assign s = sh[SYNC_STAGES-1];
    end
  endgenerate
  assign {ld_n, up_s, dn_s} = s;
  assign up_edge = ~prev_up & up_s & dn_s;
  assign dn_edge = ~prev_dn & dn_s & up_s;
  always_ff @(posedge clk or posedge p14)
    if (p14) begin
      q       <= '0;
      prev_up <= 1'b1;
      prev_dn <= 1'b1;
    end else begin
      prev_up <= up_s;
      prev_dn <= dn_s;
      q <= !ld_n                 ? {p9, p10, p1, p15} :
           (up_edge && !dn_edge) ? q + 4'd1 :
           (dn_edge && !up_edge) ? q - 4'd1 : q;
    end
  assign tcu_c = ~((q == 4'd15) & ~up_s);
  assign tcd_c = ~((q == 4'd0) & ~dn_s);
  generate
    if (TC_REG) begin : g_tc_reg
      always_ff @(posedge clk or posedge p14)
        if (p14) {p12, p13} <= 2'b11;
        else {p12, p13} <= {tcu_c, tcd_c};
    end else begin : g_tc_comb
      assign {p12, p13} = {tcu_c, tcd_c};
    end
  endgenerate
  assign {p7, p6, p2, p3} = q;
endmodule
